am_mixer: RTL and testbench

- Downstream consumer of two angleLUT sine generators: one supplies the message tone, the other the carrier.
- Computes the AM product carrier × (1 + k·message) in a 3-stage pipeline with valid/ready flow control.
- Output is a 12-bit offset-binary sample, ready for the DAC/output stage.
- Sits between the LUT generators (upstream) and the DAC interface (downstream).

---
 rtl/am_pkg.sv | 20 ++
 rtl/am_mixer_pipe_ctrl.sv | 43 ++++
 rtl/am_mixer.sv | 94 +++++++++
 tb/tb_am_mixer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// Shared constants and helpers for the AM mixer datapath.
`timescale 1ns/1ps
package am_pkg;

    localparam int SAMPLE_W   = 12;
    localparam int MIDSCALE   = 2048;
    localparam int ENV_UNITY  = 256;
    localparam int ENV_W      = 10;
    localparam int ENV_SHIFT  = 11;
    localparam int OUT_SHIFT  = 9;
    localparam int SAMPLE_MIN = 0;
    localparam int SAMPLE_MAX = 4095;

    function automatic int clamp_sample(input int v);
        if (v < SAMPLE_MIN) return SAMPLE_MIN;
        if (v > SAMPLE_MAX) return SAMPLE_MAX;
        return v;
    endfunction

endpackage

// File: rtl/am_mixer_pipe_ctrl.sv
// Generic N-stage valid/ready occupancy controller.
`timescale 1ns/1ps
module pipe_ctrl #(
    parameter int N = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic         i_ready,
    output logic         o_ready,
    output logic [N-1:0] o_load,
    output logic         o_valid
);

    logic [N-1:0] v_q;
    logic [N-1:0] v_d;
    logic [N-1:0] src;
    logic [N:0]   rdy;

    // rdy[i]: stage i can take a new beat this cycle
    always_comb begin
        rdy    = '0;
        rdy[N] = i_ready;
        for (int i = N - 1; i >= 0; i--) begin
            rdy[i] = !v_q[i] || rdy[i+1];
        end
        src    = {v_q[N-2:0], i_valid};
        v_d    = v_q;
        for (int i = 0; i < N; i++) begin
            if (rdy[i]) v_d[i] = src[i];
        end
        o_load = rdy[N-1:0] & src;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) v_q <= '0;
        else       v_q <= v_d;
    end

    assign o_ready = rdy[0];
    assign o_valid = v_q[N-1];

endmodule

// File: rtl/am_mixer.sv
// AM product carrier * (1 + k*message), 3-stage valid/ready pipeline.
`timescale 1ns/1ps
module am_mixer
    import am_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int MOD_W     = 8,
    parameter int MOD_INDEX = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_msg,
    input  logic [DATA_W-1:0] i_carrier,
    input  logic              i_mod_en,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_valid,
    input  logic              i_ready
);

    localparam int MP_W = DATA_W + MOD_W + 1;
    localparam int PR_W = DATA_W + ENV_W + 1;
    localparam int Y_W  = PR_W - OUT_SHIFT + 1;

    localparam logic [DATA_W-1:0]       MID = DATA_W'(MIDSCALE);
    localparam logic signed [MOD_W:0]   K   = (MOD_W + 1)'(MOD_INDEX);

    logic [2:0] ld;

    pipe_ctrl #(.N(3)) u_ctrl (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_ready (o_ready),
        .o_load  (ld),
        .o_valid (o_valid)
    );

    // S1: remove offset, scale message by k
    logic signed [DATA_W-1:0] msg_s;
    logic signed [DATA_W-1:0] car_s;
    logic signed [MP_W-1:0]   mprod_d;
    logic signed [MP_W-1:0]   mprod_q;
    logic signed [DATA_W-1:0] car_q;
    logic                     en_q;

    assign msg_s   = signed'(i_msg - MID);
    assign car_s   = signed'(i_carrier - MID);
    assign mprod_d = MP_W'(msg_s) * MP_W'(K);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mprod_q <= '0;
            car_q   <= '0;
            en_q    <= 1'b0;
        end else if (ld[0]) begin
            mprod_q <= mprod_d;
            car_q   <= car_s;
            en_q    <= i_mod_en;
        end
    end

    // S2: envelope and carrier product
    logic signed [MP_W-1:0] env_full;
    logic [ENV_W-1:0]       env;
    logic signed [PR_W-1:0] prod_d;
    logic signed [PR_W-1:0] prod_q;

    assign env_full = MP_W'(ENV_UNITY) + (mprod_q >>> ENV_SHIFT);
    assign env      = en_q ? env_full[ENV_W-1:0] : ENV_W'(ENV_UNITY);
    assign prod_d   = PR_W'(car_q) * PR_W'($signed({1'b0, env}));

    always_ff @(posedge i_clk) begin
        if (i_rst)      prod_q <= '0;
        else if (ld[1]) prod_q <= prod_d;
    end

    // S3: rescale, restore offset, clamp
    logic signed [PR_W-1:0] prod_sh;
    logic signed [Y_W-1:0]  y_full;
    logic [DATA_W-1:0]      y_clamped;

    assign prod_sh   = prod_q >>> OUT_SHIFT;
    assign y_full    = Y_W'(prod_sh) + Y_W'(MIDSCALE);
    assign y_clamped = DATA_W'(clamp_sample(int'(y_full)));

    always_ff @(posedge i_clk) begin
        if (i_rst)      o_sample <= MID;
        else if (ld[2]) o_sample <= y_clamped;
    end

endmodule

// File: tb/tb_am_mixer.sv
// Scoreboard bench for am_mixer with a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_am_mixer;

    localparam int K = 128;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [11:0] i_msg = '0;
    logic [11:0] i_carrier = '0;
    logic        i_mod_en = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        o_ready;
    logic        o_valid;
    logic [11:0] o_sample;

    always #5 i_clk = ~i_clk;

    am_mixer #(.DATA_W(12), .MOD_W(8), .MOD_INDEX(K)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_msg     (i_msg),
        .i_carrier (i_carrier),
        .i_mod_en  (i_mod_en),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_sample  (o_sample),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
    );

    typedef struct {
        int exp;
        int cyc;
        bit lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   cur_exp = 0;
    bit   cur_lat = 1'b0;
    bit   rnd_done = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q--;
        return q;
    endfunction

    // AM reference: y = car*(1 + k*msg) in offset binary, floor rounding
    function automatic int ref_am(input int msg, input int car, input bit en);
        int ms, cs, env, y;
        ms  = msg - 2048;
        cs  = car - 2048;
        env = en ? 256 + fdiv(ms * K, 2048) : 256;
        y   = fdiv(cs * env, 512) + 2048;
        if (y < 0) y = 0;
        if (y > 4095) y = 4095;
        return y;
    endfunction

    // Monitor and input capture in one process so occupancy is seen pre-push
    always @(negedge i_clk) begin
        if (i_rst) begin
            sb.delete();
        end else begin
            if (o_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out", int'(o_valid), 0);
                end else begin
                    mon_e = sb[0];
                    if (i_ready) begin
                        check("sample", int'(o_sample), mon_e.exp);
                        if (mon_e.lat) check("latency", cyc - mon_e.cyc, 3);
                        void'(sb.pop_front());
                    end else begin
                        check("stall_hold", int'(o_sample), mon_e.exp);
                    end
                end
            end
            if (!i_ready) check("ready_occ", int'(o_ready), int'(sb.size() < 3));
            if (i_valid && o_ready) sb.push_back('{cur_exp, cyc, cur_lat});
        end
    end

    task automatic send(input int m, input int c, input bit en,
                        input int exp, input bit lat);
        int n;
        n = 0;
        @(posedge i_clk);
        #1;
        i_valid   = 1'b1;
        i_msg     = 12'(m);
        i_carrier = 12'(c);
        i_mod_en  = en;
        cur_exp   = exp;
        cur_lat   = lat;
        @(negedge i_clk);
        while (!o_ready) begin
            n++;
            if (n > 100) begin
                check("send_timeout", n, 0);
                break;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, c;
        bit en;

        // 1: reset held with a valid beat presented
        i_valid   = 1'b1;
        i_msg     = 12'd4095;
        i_carrier = 12'd4095;
        i_mod_en  = 1'b1;
        repeat (2) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check("rst_valid", int'(o_valid), 0);
            check("rst_sample", int'(o_sample), 2048);
        end
        @(posedge i_clk);
        #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        @(negedge i_clk);
        check("rel_ready", int'(o_ready), 1);
        check("rel_valid", int'(o_valid), 0);
        idle(5);

        // 2: unity envelope, full-scale carrier
        send(2048, 4095, 1'b1, 3071, 1'b1);
        idle(5);

        // 3: envelope extremes, back to back
        send(4095, 4095, 1'b1, 3579, 1'b1);
        send(0, 0, 1'b1, 1536, 1'b1);
        idle(5);

        // 4: mod_en sampled per beat
        send(4095, 4095, 1'b0, 3071, 1'b1);
        send(4095, 4095, 1'b1, 3579, 1'b1);
        idle(5);

        // 5: ramp with a 5-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    m = i * 400;
                    c = 4095 - i * 300;
                    send(m, c, 1'b1, ref_am(m, c, 1'b1), 1'b0);
                end
                idle(1);
            end
            begin
                repeat (4) @(posedge i_clk);
                #1;
                i_ready = 1'b0;
                repeat (5) @(posedge i_clk);
                #1;
                i_ready = 1'b1;
            end
        join
        wait_empty();
        idle(2);

        // 6: reset with three beats held in flight
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m = $urandom_range(4095);
            c = $urandom_range(4095);
            send(m, c, 1'b1, ref_am(m, c, 1'b1), 1'b0);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst   = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("flush_valid", int'(o_valid), 0);
        check("flush_sample", int'(o_sample), 2048);
        check("flush_ready", int'(o_ready), 1);
        send(2048, 0, 1'b1, 1024, 1'b1);
        send(1000, 3000, 1'b1, ref_am(1000, 3000, 1'b1), 1'b1);
        idle(5);
        wait_empty();

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) begin
                        idle(1);
                    end else begin
                        m  = $urandom_range(4095);
                        c  = $urandom_range(4095);
                        en = 1'($urandom_range(1));
                        send(m, c, en, ref_am(m, c, en), 1'b0);
                    end
                end
                idle(1);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge i_clk);
                    #1;
                    i_ready = ($urandom_range(3) != 0);
                end
                i_ready = 1'b1;
            end
        join
        wait_empty();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
